alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 208 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Integer execution unit: decodes an ALU request, produces single-cycle results for
// logic/arithmetic/shift/compare ops and runs a multi-cycle shift-add multiply.
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned M_EXT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            alu_op,
  input  logic [6:0]            func7,
  input  logic [2:0]            func3,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            control_line,
  output logic                  illegal
);

  localparam int unsigned ShW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned CntW = ShW;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic                  ill_q, ill_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [3:0]            dec_op;
  logic                  dec_ill;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] acc_step;
  logic [ShW-1:0]        shamt;

  function automatic logic [3:0] f3_op(input logic [2:0] f);
    logic [3:0] op;
    unique case (f)
      3'b000:  op = OpAdd;
      3'b001:  op = OpSll;
      3'b010:  op = OpSlt;
      3'b011:  op = OpSltu;
      3'b100:  op = OpXor;
      3'b101:  op = OpSrl;
      3'b110:  op = OpOr;
      default: op = OpAnd;
    endcase
    return op;
  endfunction

  always_comb begin
    dec_op  = OpAnd;
    dec_ill = 1'b0;
    unique case (alu_op)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        if (func7 == F7Base) begin
          dec_op = f3_op(func3);
        end else if (func7 == F7Alt && func3 == 3'b000) begin
          dec_op = OpSub;
        end else if (func7 == F7Alt && func3 == 3'b101) begin
          dec_op = OpSra;
        end else if (func7 == F7Mul && func3 == 3'b000 && M_EXT != 0) begin
          dec_op = OpMul;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        // Immediate form: funct7 only matters for the shift encodings.
        dec_op = f3_op(func3);
        if (func3 == 3'b001 && func7 != F7Base) begin
          dec_ill = 1'b1;
        end else if (func3 == 3'b101) begin
          if (func7 == F7Alt) begin
            dec_op = OpSra;
          end else if (func7 != F7Base) begin
            dec_ill = 1'b1;
          end
        end
      end
    endcase
    if (dec_ill) begin
      dec_op = OpAnd;
    end
  end

  assign shamt = operand_b[ShW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (dec_op)
      OpAnd:   alu_res = operand_a & operand_b;
      OpOr:    alu_res = operand_a | operand_b;
      OpAdd:   alu_res = operand_a + operand_b;
      OpXor:   alu_res = operand_a ^ operand_b;
      OpSll:   alu_res = operand_a << shamt;
      OpSrl:   alu_res = operand_a >> shamt;
      OpSub:   alu_res = operand_a - operand_b;
      OpSra:   alu_res = $signed(operand_a) >>> shamt;
      OpSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OpSltu:  alu_res = {{(DATA_WIDTH-1){1'b0}}, operand_a < operand_b};
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ctrl_d   = ctrl_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ctrl_d = dec_op;
          ill_d  = dec_ill;
          if (dec_op == OpMul) begin
            mcand_d  = operand_a;
            mplier_d = operand_b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StBusy;
          end else begin
            result_d = dec_ill ? '0 : alu_res;
            state_d  = StDone;
          end
        end
      end
      StBusy: begin
        // One multiplier bit per cycle, LSB first; last step lands straight in result.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = acc_step;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      ctrl_q   <= '0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ctrl_q   <= ctrl_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign result       = result_q;
  assign control_line = ctrl_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random requests checked against
// a mnemonic-level reference model.
module tb_alu_exec_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    alu_op = '0;
  logic [6:0]    func7 = '0;
  logic [2:0]    func3 = '0;
  logic [DW-1:0] operand_a = '0;
  logic [DW-1:0] operand_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] result;
  logic [3:0]    control_line;
  logic          illegal;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .DATA_WIDTH(DW),
    .M_EXT     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .func7       (func7),
    .func3       (func3),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .control_line(control_line),
    .illegal     (illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference: name the instruction, then evaluate it with plain arithmetic.
  function automatic void model(input logic [1:0] aop, input logic [6:0] f7,
                                input logic [2:0] f3, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, output logic [DW-1:0] r,
                                output logic [3:0] c, output logic i);
    string       base [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string       op;
    int unsigned sh;
    logic [63:0] wide;
    op = "ILL";
    sh = int'(b % DW);
    if (aop == 2'd0) op = "ADD";
    else if (aop == 2'd1) op = "SUB";
    else if (aop == 2'd2) begin
      if (f7 == 7'h00) op = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = "SUB";
      else if (f7 == 7'h20 && f3 == 3'd5) op = "SRA";
      else if (f7 == 7'h01 && f3 == 3'd0) op = "MUL";
    end else begin
      op = base[f3];
      if (f3 == 3'd1 && f7 != 7'h00) op = "ILL";
      if (f3 == 3'd5) op = (f7 == 7'h20) ? "SRA" : (f7 == 7'h00) ? "SRL" : "ILL";
    end
    i = 1'b0;
    r = '0;
    case (op)
      "AND":  begin c = 4'd0;  r = a & b; end
      "OR":   begin c = 4'd1;  r = a | b; end
      "ADD":  begin c = 4'd2;  r = a + b; end
      "XOR":  begin c = 4'd3;  r = a ^ b; end
      "SLL":  begin c = 4'd4;  wide = {32'b0, a} * (64'd1 << sh); r = wide[DW-1:0]; end
      "SRL":  begin c = 4'd5;  r = a / (32'd1 << sh); end
      "SUB":  begin c = 4'd6;  r = a + ~b + 32'd1; end
      "SRA":  begin c = 4'd7;  wide = {{32{a[DW-1]}}, a} >> sh; r = wide[DW-1:0]; end
      "SLT":  begin c = 4'd8;  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
      "SLTU": begin c = 4'd9;  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0; end
      "MUL":  begin c = 4'd10; wide = {32'b0, a} * {32'b0, b}; r = wide[DW-1:0]; end
      default: begin c = 4'd0; i = 1'b1; end
    endcase
  endfunction

  // Issue one request from IDLE, check its outputs, stall in DONE, then retire it.
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int stall, output logic [DW-1:0] obs_r,
                        output logic [3:0] obs_c, output logic obs_i, output int lat);
    logic [DW-1:0] er;
    logic [3:0]    ec;
    logic          ei;
    model(aop, f7, f3, a, b, er, ec, ei);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_op = aop; func7 = f7; func3 = f3; operand_a = a; operand_b = b;
    @(negedge clk);
    lat = 1;
    // Garbage on the inputs and a held in_valid must not disturb the accepted request.
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom); alu_op = 2'($urandom); func7 = 7'($urandom);
      func3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), (ec == 4'd10) ? 64'd33 : 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_ctrl"}, 64'(control_line), 64'(ec));
    chk({tag, "_illegal"}, 64'(illegal), 64'(ei));
    obs_r = result; obs_c = control_line; obs_i = illegal;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_result"}, 64'(result), 64'(er));
      chk({tag, "_hold_busy"}, {62'd0, in_ready, out_valid}, 64'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_retire"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    logic [DW-1:0] r;
    logic [3:0]    c;
    logic          il;
    int            lat;
    logic [6:0]    f7_pick [4];
    logic          seen;

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ctrl", 64'(control_line), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_op("sub", 2'b10, 7'h20, 3'b000, 32'd5, 32'd7, 0, r, c, il, lat);
    chk("sub_const", {28'd0, c, r}, {28'd0, 4'b0110, 32'hFFFF_FFFE});

    run_op("mul", 2'b10, 7'h01, 3'b000, 32'h1_0001, 32'h1_0001, 0, r, c, il, lat);
    chk("mul_const", {28'd0, c, r}, {28'd0, 4'b1010, 32'h0002_0001});
    chk("mul_lat_const", 64'(lat), 64'd33);

    run_op("srai", 2'b11, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 0, r, c, il, lat);
    chk("srai_const", {28'd0, c, r}, {28'd0, 4'b0111, 32'hF800_0000});

    run_op("ill", 2'b10, 7'h02, 3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 0, r, c, il, lat);
    chk("ill_const", {27'd0, il, c, r}, {27'd0, 1'b1, 4'b0000, 32'd0});

    run_op("stall", 2'b00, 7'h7F, 3'b111, 32'hFFFF_FFFF, 32'd2, 5, r, c, il, lat);
    chk("stall_const", {28'd0, c, r}, {28'd0, 4'b0010, 32'd1});

    run_op("slli_bad", 2'b11, 7'h20, 3'b001, 32'd1, 32'd3, 0, r, c, il, lat);
    run_op("sra_shamt", 2'b10, 7'h20, 3'b101, 32'h8000_00F0, 32'hFFFF_FFE4, 1, r, c, il, lat);
    run_op("slt_neg", 2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 0, r, c, il, lat);
    run_op("sltu_neg", 2'b11, 7'h55, 3'b011, 32'hFFFF_FFFF, 32'd1, 0, r, c, il, lat);

    f7_pick = '{7'h00, 7'h20, 7'h01, 7'h00};
    for (int n = 0; n < 40; n++) begin
      logic [6:0] f7r;
      f7r = (n % 5 == 4) ? 7'($urandom) : f7_pick[$urandom_range(0, 3)];
      run_op("rand", 2'($urandom_range(0, 3)), f7r, 3'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), r, c, il, lat);
    end

    // Abort a multiply mid-flight with an asynchronous reset.
    in_valid = 1'b1; alu_op = 2'b10; func7 = 7'h01; func3 = 3'b000;
    operand_a = $urandom | 32'h1; operand_b = $urandom | 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", {62'd0, in_ready, out_valid}, 64'b00);
    rst = 1'b1;
    #1;
    chk("abort_rst_out_valid", 64'(out_valid), 64'd0);
    chk("abort_rst_result", 64'(result), 64'd0);
    chk("abort_rst_ctrl", 64'(control_line), 64'd0);
    chk("abort_rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    run_op("after_abort", 2'b01, 7'h00, 3'b000, 32'd10, 32'd3, 0, r, c, il, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
